// File: rtl/uart_tx_arbiter_pkg.sv
// Shared encodings for the UART TX arbiter: combined FSM state names and 8N1 framing constants.
// The chip-side printer model reuses these so both ends agree on the frame layout.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOCK  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 shifter: a load pulse starts a START/DATA/STOP frame on the registered tx line;
// done is high during the final STOP cycle so the caller can hand over without a bubble.
module uart_tx_serializer
    import uart_tx_arbiter_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 done
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);

    tx_state_t            phase_q, phase_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [CW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 baud_end;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            phase_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= STOP_BIT;
        end else begin
            phase_q <= phase_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        phase_d = phase_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (phase_q != ST_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end
        case (phase_q)
            ST_START: begin
                if (baud_end) begin
                    phase_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    if (bit_q == BIT_LAST) begin
                        phase_d = ST_STOP;
                        tx_d    = STOP_BIT;
                    end else begin
                        // Next bit is presented from the unshifted word so tx changes on the bit boundary.
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    phase_d = ST_IDLE;
                end
            end
            default: begin
                tx_d   = STOP_BIT;
                baud_d = '0;
                if (load) begin
                    phase_d = ST_START;
                    shift_d = data;
                    tx_d    = START_BIT;
                end
            end
        endcase
    end

    always_comb begin
        tx   = tx_q;
        done = (phase_q == ST_STOP) && baud_end;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-atomic sharing of one UART TX pin among NUM_REQ byte sources.
// A granted source keeps the line until its last byte's STOP bit or until it stalls MAX_GAP cycles.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int MAX_GAP      = 255
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic                   gap_abort
);

    localparam int RW = $clog2(NUM_REQ);
    localparam int GW = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(MAX_GAP - 1);

    // ST_START here stands for "frame owned by the serializer" (its START, DATA and STOP phases).
    tx_state_t     state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic [RW-1:0] rr_q, rr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          last_q, last_d;
    logic          gap_abort_q, gap_abort_d;

    logic [7:0]    src_byte [NUM_REQ];
    logic [RW-1:0] gidx, rr_after;
    logic [2:0]    pick;
    logic          found, xfer, ser_done;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
        assign src_byte[gi] = req_data[8*gi +: 8];
    end

    assign gidx     = grant_q[RW-1:0];
    assign rr_after = (gidx == RW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    assign xfer     = (state_q == ST_LOCK) && req_valid[gidx];

    always_comb begin : arb_pick
        logic [RW:0] slot;
        pick  = '0;
        found = 1'b0;
        slot  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = {1'b0, rr_q} + (RW+1)'(k);
            if (slot >= (RW+1)'(NUM_REQ)) slot = slot - (RW+1)'(NUM_REQ);
            if (!found && req_valid[slot[RW-1:0]]) begin
                found = 1'b1;
                pick  = 3'(slot[RW-1:0]);
            end
        end
    end

    uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
        .clk  (clk),
        .rstb (rstb),
        .load (xfer),
        .data (src_byte[gidx]),
        .tx   (tx),
        .done (ser_done)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            gap_q       <= '0;
            last_q      <= 1'b0;
            gap_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            gap_q       <= gap_d;
            last_q      <= last_d;
            gap_abort_q <= gap_abort_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        gap_d       = gap_q;
        last_d      = last_q;
        gap_abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_LOCK;
                    grant_d = pick;
                    gap_d   = '0;
                end
            end
            ST_LOCK: begin
                if (xfer) begin
                    state_d = ST_START;
                    last_d  = req_last[gidx];
                    gap_d   = '0;
                end else if (gap_q == GAP_LAST) begin
                    state_d     = ST_IDLE;
                    rr_d        = rr_after;
                    gap_d       = '0;
                    gap_abort_d = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                if (ser_done) begin
                    gap_d   = '0;
                    state_d = last_q ? ST_IDLE : ST_LOCK;
                    if (last_q) rr_d = rr_after;
                end
            end
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == ST_LOCK) req_ready[gidx] = 1'b1;
        busy      = (state_q != ST_IDLE);
        grant_id  = grant_q;
        gap_abort = gap_abort_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-source byte queues feed the DUT, a line monitor
// decodes 8N1 frames, and each scenario task pops decoded frames against expected ones.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int CPB  = 4;
    localparam int GAP  = 8;
    localparam int FLEN = 10 * CPB;

    typedef struct { logic [7:0] data; logic last; } item_t;
    typedef struct { logic [7:0] data; int src; } exp_t;
    typedef struct { logic [7:0] data; logic [2:0] grant; logic [FLEN-1:0] wave; logic busy_end; } rx_t;

    logic              clk;
    logic              rstb;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx;
    logic              busy;
    logic [2:0]        grant_id;
    logic              gap_abort;

    item_t           src_q [NREQ][$];
    exp_t            exp_q [$];
    rx_t             rx_q  [$];
    logic [NREQ-1:0] took;
    int              checks;
    int              passes;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .CLKS_PER_BIT(CPB), .MAX_GAP(GAP)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id),
        .gap_abort (gap_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line waveform: each frame bit (index 0 = start) held for CPB cycles.
    function automatic logic [FLEN-1:0] expand(input logic [9:0] f);
        logic [FLEN-1:0] w;
        for (int p = 0; p < FLEN; p++) w[p] = f[p / CPB];
        return w;
    endfunction

    task automatic send(input int s, input logic [7:0] d, input logic last, input bit expect_out);
        item_t it;
        exp_t  e;
        it.data = d;
        it.last = last;
        src_q[s].push_back(it);
        if (expect_out) begin
            e.data = d;
            e.src  = s;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (rx_q.size() >= n) break;
            @(negedge clk);
            #1;
        end
        if (rx_q.size() >= n) ok = 1'b1;
    endtask

    // Source driver: pops a byte after the edge it was accepted on, then presents the next one.
    initial begin
        item_t it;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) took[i] = req_valid[i] && req_ready[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (took[i] && src_q[i].size() > 0) src_q[i].delete(0);
                if (src_q[i].size() > 0) begin
                    it = src_q[i][0];
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = it.data;
                    req_last[i]        = it.last;
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    // Line monitor: a falling edge on an idle line starts a frame; sampled once per cycle.
    initial begin
        rx_t  r;
        logic tx_prev;
        bit   aborted;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rstb === 1'b1 && tx_prev === 1'b1 && tx === 1'b0) begin
                r.grant   = grant_id;
                r.wave    = '0;
                r.wave[0] = tx;
                aborted   = 1'b0;
                for (int p = 1; p < FLEN; p++) begin
                    @(negedge clk);
                    if (rstb !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    r.wave[p] = tx;
                end
                r.busy_end = busy;
                for (int b = 0; b < 8; b++) r.data[b] = r.wave[CPB*(b+1) + CPB/2];
                if (!aborted) rx_q.push_back(r);
            end
            tx_prev = (rstb === 1'b1) ? tx : 1'b1;
        end
    end

    task automatic test_reset();
        int bad;
        rstb = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else passes++;
        checks++; if (grant_id !== 3'd0) $display("FAIL reset_grant: got %0d want 0", grant_id); else passes++;
        checks++; if (gap_abort !== 1'b0) $display("FAIL reset_gap_abort: got %b want 0", gap_abort); else passes++;
        rstb = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || req_ready !== 4'b0000) bad++;
        end
        checks++; if (bad != 0) $display("FAIL idle_100: got %0d non-idle cycles want 0", bad); else passes++;
        $display("test_reset: idle after reset checked");
    endtask

    task automatic test_single_byte();
        rx_t r;
        exp_t e;
        bit ok;
        logic [9:0] pat;
        pat = 10'b1010000010;
        rx_q.delete();
        exp_q.delete();
        @(negedge clk);
        send(2, 8'h41, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000) $display("FAIL single_idle_ready: got %b want 0000", req_ready); else passes++;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) $display("FAIL single_lock_ready: got %b want 0100", req_ready); else passes++;
        checks++; if (grant_id !== 3'd2) $display("FAIL single_grant: got %0d want 2", grant_id); else passes++;
        wait_rx(1, 200, ok);
        checks++; if (!ok) $display("FAIL single_timeout: got %0d frames want 1", rx_q.size()); else passes++;
        if (ok) begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (r.data !== e.data) $display("FAIL single_data: got %02h want %02h", r.data, e.data); else passes++;
            checks++; if (r.wave !== expand(pat)) $display("FAIL single_wave: got %h want %h", r.wave, expand(pat)); else passes++;
            checks++; if (r.busy_end !== 1'b1) $display("FAIL single_busy_last_stop: got %b want 1", r.busy_end); else passes++;
            @(negedge clk);
            checks++; if (busy !== 1'b0) $display("FAIL single_busy_drop: got %b want 0", busy); else passes++;
        end
        $display("test_single_byte: src2 0x41 framed");
    endtask

    task automatic test_atomicity();
        rx_t r;
        exp_t e;
        int early;
        rx_q.delete();
        exp_q.delete();
        @(negedge clk);
        send(0, 8'h41, 1'b0, 1'b1);
        send(0, 8'h42, 1'b1, 1'b1);
        send(1, 8'h43, 1'b1, 1'b1);
        early = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            #1;
            if (req_ready[1] === 1'b1 && rx_q.size() < 2) early++;
            if (rx_q.size() >= 3) break;
        end
        checks++; if (rx_q.size() < 3) $display("FAIL atom_timeout: got %0d frames want 3", rx_q.size()); else passes++;
        checks++; if (early != 0) $display("FAIL atom_src1_early_ready: got %0d cycles want 0", early); else passes++;
        for (int f = 0; f < 3 && rx_q.size() > 0 && exp_q.size() > 0; f++) begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (r.data !== e.data) $display("FAIL atom_data[%0d]: got %02h want %02h", f, r.data, e.data); else passes++;
            checks++; if (r.grant !== 3'(e.src)) $display("FAIL atom_grant[%0d]: got %0d want %0d", f, r.grant, e.src); else passes++;
            checks++; if (r.wave !== expand({1'b1, e.data, 1'b0})) $display("FAIL atom_wave[%0d]: got %h want %h", f, r.wave, expand({1'b1, e.data, 1'b0})); else passes++;
        end
        $display("test_atomicity: src0 AB then src1 C checked");
    endtask

    task automatic test_gap_abort();
        rx_t r;
        exp_t e;
        bit ok;
        int first_k, hi;
        logic [NREQ-1:0] rdy1;
        logic busy_at;
        rx_q.delete();
        exp_q.delete();
        @(negedge clk);
        send(3, 8'h55, 1'b0, 1'b1);
        wait_rx(1, 200, ok);
        checks++; if (!ok) $display("FAIL gap_timeout: got %0d frames want 1", rx_q.size()); else passes++;
        if (ok) begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (r.data !== e.data) $display("FAIL gap_data: got %02h want %02h", r.data, e.data); else passes++;
            checks++; if (r.grant !== 3'd3) $display("FAIL gap_grant: got %0d want 3", r.grant); else passes++;
            first_k = 0;
            hi = 0;
            rdy1 = '0;
            busy_at = 1'bx;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (k == 1) rdy1 = req_ready;
                if (gap_abort === 1'b1) begin
                    hi++;
                    if (first_k == 0) begin
                        first_k = k;
                        busy_at = busy;
                    end
                end
            end
            checks++; if (rdy1 !== 4'b1000) $display("FAIL gap_relock_ready: got %b want 1000", rdy1); else passes++;
            checks++; if (first_k != GAP + 1) $display("FAIL gap_abort_time: got cycle %0d want %0d", first_k, GAP + 1); else passes++;
            checks++; if (hi != 1) $display("FAIL gap_abort_width: got %0d cycles want 1", hi); else passes++;
            checks++; if (busy_at !== 1'b0) $display("FAIL gap_busy_after_abort: got %b want 0", busy_at); else passes++;
        end
        send(0, 8'h30, 1'b1, 1'b1);
        send(3, 8'h33, 1'b1, 1'b1);
        wait_rx(2, 300, ok);
        checks++; if (!ok) $display("FAIL gap_next_timeout: got %0d frames want 2", rx_q.size()); else passes++;
        for (int f = 0; f < 2 && rx_q.size() > 0 && exp_q.size() > 0; f++) begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (r.data !== e.data) $display("FAIL gap_next_data[%0d]: got %02h want %02h", f, r.data, e.data); else passes++;
            checks++; if (r.grant !== 3'(e.src)) $display("FAIL gap_next_grant[%0d]: got %0d want %0d", f, r.grant, e.src); else passes++;
        end
        $display("test_gap_abort: abort timing and next grant checked");
    endtask

    task automatic test_round_robin();
        rx_t r;
        exp_t e;
        bit ok;
        rx_q.delete();
        exp_q.delete();
        @(negedge clk);
        for (int s = 0; s < NREQ; s++) send(s, 8'h10 + 8'(s), 1'b1, 1'b1);
        send(0, 8'h20, 1'b1, 1'b1);
        wait_rx(5, 600, ok);
        checks++; if (!ok) $display("FAIL rr_timeout: got %0d frames want 5", rx_q.size()); else passes++;
        for (int f = 0; f < 5 && rx_q.size() > 0 && exp_q.size() > 0; f++) begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (r.grant !== 3'(e.src)) $display("FAIL rr_grant[%0d]: got %0d want %0d", f, r.grant, e.src); else passes++;
            checks++; if (r.data !== e.data) $display("FAIL rr_data[%0d]: got %02h want %02h", f, r.data, e.data); else passes++;
        end
        $display("test_round_robin: grant order 0,1,2,3,0 checked");
    endtask

    task automatic test_reset_mid_frame();
        rx_t r;
        exp_t e;
        bit ok, found;
        rx_q.delete();
        exp_q.delete();
        @(negedge clk);
        send(1, 8'hF7, 1'b1, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) $display("FAIL midrst_no_start: got tx %b want start bit 0", tx); else passes++;
        repeat (4*CPB + 1) @(negedge clk);
        checks++; if (tx !== 1'b0) $display("FAIL midrst_bit3: got %b want 0", tx); else passes++;
        #2;
        rstb = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) $display("FAIL midrst_tx_async: got %b want 1", tx); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passes++;
        checks++; if (grant_id !== 3'd0) $display("FAIL midrst_grant: got %0d want 0", grant_id); else passes++;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        checks++; if (rx_q.size() != 0) $display("FAIL midrst_truncated_frame: got %0d frames want 0", rx_q.size()); else passes++;
        send(1, 8'h41, 1'b1, 1'b1);
        wait_rx(1, 200, ok);
        checks++; if (!ok) $display("FAIL midrst_timeout: got %0d frames want 1", rx_q.size()); else passes++;
        if (ok) begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (r.data !== e.data) $display("FAIL midrst_data: got %02h want %02h", r.data, e.data); else passes++;
            checks++; if (r.grant !== 3'd1) $display("FAIL midrst_grant_after: got %0d want 1", r.grant); else passes++;
            checks++; if (r.wave !== expand({1'b1, e.data, 1'b0})) $display("FAIL midrst_wave: got %h want %h", r.wave, expand({1'b1, e.data, 1'b0})); else passes++;
        end
        $display("test_reset_mid_frame: truncation and recovery checked");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        passes = 0;
        rstb   = 1'b0;
        test_reset();
        test_single_byte();
        test_atomicity();
        test_gap_abort();
        test_round_robin();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
